// File: rtl/rfaludm_pkg.sv
// Shared definitions for the multi-cycle register-file / ALU / data-memory datapath:
// LEGv8 opcodes, ALU control encoding, FSM state and opcode classification.
package rfaludm_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_ORR = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_RTYPE   = 2'd0,
        CLS_LOAD    = 2'd1,
        CLS_STORE   = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_t;

    // Sort an opcode into the path it takes through the FSM.
    function automatic op_class_t classify(input logic [10:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CLS_RTYPE;
            OP_LDUR:                        cls = CLS_LOAD;
            OP_STUR:                        cls = CLS_STORE;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // ALU operation for an R-type opcode; everything else uses ADD (address generation).
    function automatic logic [1:0] alu_ctrl_for(input logic [10:0] op);
        logic [1:0] ctrl;
        case (op)
            OP_AND:  ctrl = ALU_AND;
            OP_ORR:  ctrl = ALU_ORR;
            OP_SUB:  ctrl = ALU_SUB;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/rf_alu_dm_multicycle_alu.sv
// Combinational LEGv8 ALU: AND / ORR / ADD / SUB on DATA_W-bit operands, plus a zero flag.
module legv8_alu #(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        alu_ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    import rfaludm_pkg::*;

    // Select the operation; arithmetic wraps modulo 2^DATA_W.
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rf_alu_dm_multicycle.sv
// Multi-cycle LEGv8 datapath slice: register file, ALU, data memory and the
// IDLE/DECODE/EXEC/MEM/WB sequencer. One instruction at a time over valid/ready.
// Optional feature macro: XZR_EN (top register reads as zero, writes to it are discarded).
module rf_alu_dm_multicycle #(
    parameter int DATA_W   = 64,
    parameter int NREG     = 32,
    parameter int DM_DEPTH = 64,
    parameter int MEM_WAIT = 0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    InstrValid,
    output logic                    InstrReady,
    input  logic [10:0]             Opcode,
    input  logic [$clog2(NREG)-1:0] Rm,
    input  logic [$clog2(NREG)-1:0] Rn,
    input  logic [$clog2(NREG)-1:0] Rd,
    input  logic [8:0]              DAddr,
    output logic                    Done,
    output logic                    Illegal,
    output logic                    Zero,
    output logic [DATA_W-1:0]       Result,
    input  logic                    DbgWe,
    input  logic [$clog2(NREG)-1:0] DbgReg,
    input  logic [DATA_W-1:0]       DbgWData,
    output logic [DATA_W-1:0]       DbgRData
);
    import rfaludm_pkg::*;

    localparam int RA_W = $clog2(NREG);
    localparam int AW   = $clog2(DM_DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
`ifdef XZR_EN
    localparam logic [RA_W-1:0] XZR_IDX = RA_W'(NREG - 1);
`endif

    state_t            state;
    logic [10:0]       op_q;
    logic [RA_W-1:0]   rm_q;
    logic [RA_W-1:0]   rn_q;
    logic [RA_W-1:0]   rd_q;
    logic [8:0]        daddr_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [AW-1:0]     idx_q;
    logic [3:0]        wait_cnt;

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] dm [DM_DEPTH];

    op_class_t         op_cls;
    logic              mem_exit;
    logic [1:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] daddr_sext;

    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Register read port; the zero register, when enabled, never shows its storage.
    function automatic logic [DATA_W-1:0] rf_read(input logic [RA_W-1:0] r);
`ifdef XZR_EN
        if (r == XZR_IDX) begin
            return '0;
        end
`endif
        return rf[r];
    endfunction

    assign op_cls     = classify(op_q);
    assign mem_exit   = (wait_cnt == WAIT_LAST);
    assign daddr_sext = {{(DATA_W-9){daddr_q[8]}}, daddr_q};
    assign alu_ctrl   = (op_cls == CLS_RTYPE) ? alu_ctrl_for(op_q) : ALU_ADD;
    assign alu_b      = (op_cls == CLS_RTYPE) ? b_q : daddr_sext;

    assign InstrReady = (state == IDLE);
    assign Done       = (state == WB);
    assign DbgRData   = rf_read(DbgReg);

    legv8_alu #(.DATA_W(DATA_W)) u_alu (
        .alu_ctrl (alu_ctrl),
        .a        (a_q),
        .b        (alu_b),
        .result   (alu_result),
        .zero     (alu_zero)
    );

    // Single register-file write port: debug writes in IDLE lose to a new instruction,
    // R-type results land as EXEC hands over to WB, loads land as MEM hands over to WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_result;
        if (state == IDLE && DbgWe && !InstrValid) begin
            rf_we    = 1'b1;
            rf_waddr = DbgReg;
            rf_wdata = DbgWData;
        end else if (state == EXEC && op_cls == CLS_RTYPE) begin
            rf_we    = 1'b1;
            rf_wdata = alu_result;
        end else if (state == MEM && mem_exit && op_cls == CLS_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = dm[idx_q];
        end
`ifdef XZR_EN
        if (rf_waddr == XZR_IDX) begin
            rf_we = 1'b0;
        end
`endif
    end

    // Register file storage, cleared by reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Data memory keeps its contents across reset; a store commits only on its MEM exit edge.
    always_ff @(posedge Clock) begin
        if (state == MEM && mem_exit && op_cls == CLS_STORE) begin
            dm[idx_q] <= b_q;
        end
    end

    // Instruction sequencer with operand, address and status registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            op_q     <= '0;
            rm_q     <= '0;
            rn_q     <= '0;
            rd_q     <= '0;
            daddr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            wait_cnt <= '0;
            Zero     <= 1'b0;
            Illegal  <= 1'b0;
            Result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InstrValid) begin
                        op_q    <= Opcode;
                        rm_q    <= Rm;
                        rn_q    <= Rn;
                        rd_q    <= Rd;
                        daddr_q <= DAddr;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a_q   <= rf_read(rn_q);
                    b_q   <= (op_cls == CLS_STORE) ? rf_read(rd_q) : rf_read(rm_q);
                    state <= EXEC;
                end
                EXEC: begin
                    case (op_cls)
                        CLS_RTYPE: begin
                            Zero    <= alu_zero;
                            Result  <= alu_result;
                            Illegal <= 1'b0;
                            state   <= WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            idx_q    <= alu_result[AW-1:0];
                            wait_cnt <= '0;
                            state    <= MEM;
                        end
                        default: begin
                            Illegal <= 1'b1;
                            state   <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_exit) begin
                        Result  <= (op_cls == CLS_LOAD) ? dm[idx_q] : b_q;
                        Illegal <= 1'b0;
                        state   <= WB;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
